// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, writeback select and load-type encodings.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  // Writeback result select (encoding 3 aliases ALU)
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  // Load funct3 encodings; any other value behaves as a word load
  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half lane of a loaded word and sign- or zero-extends it.
module load_align
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = cpu_pkg::XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection and extension; word loads ignore the address bits
  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    value     = word;
    case (addr)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    half_lane = addr[1] ? word[31:16] : word[15:0];
    case (load_type)
      LD_B:    value = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      LD_BU:   value = {{(XLEN-8){1'b0}}, byte_lane};
      LD_H:    value = {{(XLEN-16){half_lane[15]}}, half_lane};
      LD_HU:   value = {{(XLEN-16){1'b0}}, half_lane};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load alignment, register-file write port,
// write-through bypass for decode reads, and retired-instruction counter.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = cpu_pkg::XLEN,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [XLEN-1:0]  mem_pc,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_data,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_load_type,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             hold,
  input  logic             flush,
  input  logic [4:0]       r1_addr,
  input  logic [4:0]       r2_addr,
  input  logic [XLEN-1:0]  r1_raw,
  input  logic [XLEN-1:0]  r2_raw,
  output logic [XLEN-1:0]  r1_fwd,
  output logic [XLEN-1:0]  r2_fwd,
  output logic [4:0]       rf_w_addr,
  output logic [XLEN-1:0]  rf_din,
  output logic             rf_write_en,
  output logic             wb_valid,
  output logic [XLEN-1:0]  wb_pc,
  output logic [CNT_W-1:0] instr_count
);

  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] load_data;
  logic [1:0]      wb_sel;
  logic [2:0]      load_type;
  logic [4:0]      rd;
  logic            reg_write;
  logic            retired;
  logic [XLEN-1:0] load_value;
  logic [XLEN-1:0] result;

  // MEM/WB register with flush > hold > capture; retired marks an instruction
  // that has already spent one cycle in WB so a held instruction acts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_pc      <= '0;
      alu_result <= '0;
      load_data  <= '0;
      wb_sel     <= WB_ALU;
      load_type  <= 3'b000;
      rd         <= 5'd0;
      reg_write  <= 1'b0;
      retired    <= 1'b0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      retired  <= 1'b0;
    end else if (hold) begin
      retired <= retired | wb_valid;
    end else begin
      wb_valid   <= mem_valid;
      wb_pc      <= mem_pc;
      alu_result <= mem_alu_result;
      load_data  <= mem_load_data;
      wb_sel     <= mem_wb_sel;
      load_type  <= mem_load_type;
      rd         <= mem_rd;
      reg_write  <= mem_reg_write;
      retired    <= 1'b0;
    end
  end

  // Count each instruction once, on its first cycle in WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
    end else if (wb_valid && !retired) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .word      (load_data),
    .addr      (alu_result[1:0]),
    .load_type (load_type),
    .value     (load_value)
  );

  // Result select; PC+4 wraps at XLEN
  always_comb begin
    result = alu_result;
    case (wb_sel)
      WB_LOAD: result = load_value;
      WB_PC4:  result = wb_pc + XLEN'(4);
      default: result = alu_result;
    endcase
  end

  assign rf_write_en = wb_valid & reg_write & (rd != 5'd0) & ~retired;
  assign rf_w_addr   = rd;
  assign rf_din      = result;

  // Write-through bypass so decode sees a same-cycle register write
  always_comb begin
    r1_fwd = r1_raw;
    r2_fwd = r2_raw;
    if (rf_write_en && (r1_addr == rf_w_addr)) r1_fwd = rf_din;
    if (rf_write_en && (r2_addr == rf_w_addr)) r2_fwd = rf_din;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage; a second instance with a 4-bit counter checks wrap.
module tb_wb_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_pc, mem_alu_result, mem_load_data;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_load_type;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, hold, flush;
  logic [4:0]  r1_addr, r2_addr;
  logic [31:0] r1_raw, r2_raw;

  logic [31:0] r1_fwd, r2_fwd, rf_din, wb_pc;
  logic [4:0]  rf_w_addr;
  logic        rf_write_en, wb_valid;
  logic [31:0] instr_count;

  logic [31:0] s_r1_fwd, s_r2_fwd, s_rf_din, s_wb_pc;
  logic [4:0]  s_rf_w_addr;
  logic        s_rf_write_en, s_wb_valid;
  logic [3:0]  s_instr_count;

  int total = 0;
  int bad   = 0;
  int wcount;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_wb_sel(mem_wb_sel), .mem_load_type(mem_load_type), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .hold(hold), .flush(flush),
    .r1_addr(r1_addr), .r2_addr(r2_addr), .r1_raw(r1_raw), .r2_raw(r2_raw),
    .r1_fwd(r1_fwd), .r2_fwd(r2_fwd), .rf_w_addr(rf_w_addr), .rf_din(rf_din),
    .rf_write_en(rf_write_en), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .instr_count(instr_count)
  );

  wb_stage #(.XLEN(32), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_wb_sel(mem_wb_sel), .mem_load_type(mem_load_type), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .hold(hold), .flush(flush),
    .r1_addr(r1_addr), .r2_addr(r2_addr), .r1_raw(r1_raw), .r2_raw(r2_raw),
    .r1_fwd(s_r1_fwd), .r2_fwd(s_r2_fwd), .rf_w_addr(s_rf_w_addr), .rf_din(s_rf_din),
    .rf_write_en(s_rf_write_en), .wb_valid(s_wb_valid), .wb_pc(s_wb_pc),
    .instr_count(s_instr_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [1:0] sel, input logic [2:0] lt,
                       input logic [4:0] rd, input logic rw);
    mem_valid      = v;
    mem_pc         = pc;
    mem_alu_result = alu;
    mem_load_data  = ld;
    mem_wb_sel     = sel;
    mem_load_type  = lt;
    mem_rd         = rd;
    mem_reg_write  = rw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_case(input string tag, input logic [2:0] lt, input logic [31:0] addr,
                           input logic [31:0] exp);
    issue(1'b1, 32'h100, addr, 32'h80F1_7F02, WB_LOAD, lt, 5'd3, 1'b1);
    tick();
    chk({tag, "_din"}, 64'(rf_din), 64'(exp));
    chk({tag, "_we"}, 64'(rf_write_en), 64'd1);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    r1_addr = 5'd0; r2_addr = 5'd0; r1_raw = 32'h0; r2_raw = 32'h0;
    issue(1'b0, 32'h0, 32'h0, 32'h0, WB_ALU, LD_W, 5'd0, 1'b0);
    tick(); tick();
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_we", 64'(rf_write_en), 64'd0);
    chk("rst_din", 64'(rf_din), 64'd0);
    chk("rst_cnt", 64'(instr_count), 64'd0);
    rst = 1'b0;

    // Load alignment
    load_case("lb1",  LD_B,  32'h1, 32'h0000_007F);
    load_case("lb2",  LD_B,  32'h2, 32'hFFFF_FFF1);
    load_case("lbu3", LD_BU, 32'h3, 32'h0000_0080);
    load_case("lh2",  LD_H,  32'h2, 32'hFFFF_80F1);
    load_case("lhu0", LD_HU, 32'h0, 32'h0000_7F02);
    load_case("lw3",  LD_W,  32'h3, 32'h80F1_7F02);

    // Bypass
    issue(1'b1, 32'h200, 32'h1234, 32'h0, WB_ALU, LD_W, 5'd5, 1'b1);
    tick();
    r1_addr = 5'd5; r1_raw = 32'h0; r2_addr = 5'd6; r2_raw = 32'hAAAA;
    #1;
    chk("byp_r1", 64'(r1_fwd), 64'h1234);
    chk("byp_r2", 64'(r2_fwd), 64'hAAAA);
    chk("byp_cnt", 64'(instr_count), 64'd6);
    issue(1'b1, 32'h204, 32'h55, 32'h0, WB_ALU, LD_W, 5'd0, 1'b1);
    tick();
    r1_addr = 5'd0; r1_raw = 32'h77;
    #1;
    chk("x0_we", 64'(rf_write_en), 64'd0);
    chk("x0_r1", 64'(r1_fwd), 64'h77);

    // Hold for three cycles: one write, one count
    issue(1'b1, 32'h208, 32'h777, 32'h0, WB_ALU, LD_W, 5'd7, 1'b1);
    tick();
    hold = 1'b1;
    issue(1'b1, 32'h20C, 32'h888, 32'h0, WB_ALU, LD_W, 5'd8, 1'b1);
    wcount = int'(rf_write_en);
    tick(); wcount += int'(rf_write_en);
    chk("hold_addr", 64'(rf_w_addr), 64'd7);
    tick(); wcount += int'(rf_write_en);
    chk("hold_writes", 64'(wcount), 64'd1);
    chk("hold_valid", 64'(wb_valid), 64'd1);
    chk("hold_cnt", 64'(instr_count), 64'd9);
    hold = 1'b0; mem_valid = 1'b0;
    tick();
    chk("bubble_valid", 64'(wb_valid), 64'd0);
    chk("bubble_cnt", 64'(instr_count), 64'd9);

    // Flush beats hold
    issue(1'b1, 32'h210, 32'h999, 32'h0, WB_ALU, LD_W, 5'd9, 1'b1);
    flush = 1'b1; hold = 1'b1;
    tick();
    flush = 1'b0; hold = 1'b0;
    chk("flush_valid", 64'(wb_valid), 64'd0);
    chk("flush_we", 64'(rf_write_en), 64'd0);
    tick();
    chk("flush_cnt", 64'(instr_count), 64'd9);

    // PC+4 wrap, then async reset mid-hold
    issue(1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, WB_PC4, LD_W, 5'd1, 1'b1);
    tick();
    chk("pc4_din", 64'(rf_din), 64'd0);
    chk("pc4_we", 64'(rf_write_en), 64'd1);
    chk("pc4_pc", 64'(wb_pc), 64'hFFFF_FFFC);
    hold = 1'b1; r1_addr = 5'd1; r1_raw = 32'h99;
    #1;
    chk("pc4_byp", 64'(r1_fwd), 64'd0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(wb_valid), 64'd0);
    chk("arst_we", 64'(rf_write_en), 64'd0);
    chk("arst_cnt", 64'(instr_count), 64'd0);
    chk("arst_byp", 64'(r1_fwd), 64'h99);
    tick();
    mem_valid = 1'b0; hold = 1'b0;
    rst = 1'b0;

    // Ten back-to-back instructions, two without register write
    wcount = 0;
    for (int i = 0; i < 10; i++) begin
      issue(1'b1, 32'(32'h400 + 4*i), 32'(i), 32'h0, WB_ALU, LD_W, 5'(i + 1),
            (i != 3 && i != 7));
      tick();
      wcount += int'(rf_write_en);
    end
    mem_valid = 1'b0;
    tick();
    chk("b2b_cnt", 64'(instr_count), 64'd10);
    chk("b2b_writes", 64'(wcount), 64'd8);
    chk("small_cnt10", 64'(s_instr_count), 64'd10);

    // Drive the 4-bit counter through its maximum and wrap
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 32'h500, 32'h1, 32'h0, WB_ALU, LD_W, 5'd2, 1'b1);
      tick();
    end
    mem_valid = 1'b0;
    tick();
    chk("small_max", 64'(s_instr_count), 64'd15);
    issue(1'b1, 32'h504, 32'h1, 32'h0, WB_ALU, LD_W, 5'd2, 1'b1);
    tick();
    mem_valid = 1'b0;
    tick();
    chk("small_wrap", 64'(s_instr_count), 64'd0);
    chk("big_cnt16", 64'(instr_count), 64'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
